// File: rtl/lau_lin2log.sv
// rtl/lau_lin2log.sv - linear two's-complement to LNS (sign, Q6.10 log2) operand converter
module lau_lin2log #(
    parameter int               DATA_W    = 16,
    parameter int               FRAC_BITS = 10,
    parameter int               LOG_W     = 16,
    parameter logic [LOG_W-1:0] ZERO_CODE = 16'hFF1C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [LOG_W-1:0]  out_l
);

    localparam int CNT_W = $clog2(FRAC_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_sign;
    logic [DATA_W-1:0]    r_mag;
    logic [5:0]           r_exp;
    logic [15:0]          r_m;
    logic [FRAC_BITS-1:0] r_frac;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_out_s;
    logic [LOG_W-1:0]     r_out_l;

    logic [DATA_W-1:0]    w_abs;
    logic [5:0]           w_lead;
    logic [5:0]           w_shift;
    logic [DATA_W-1:0]    w_norm;
    logic [DATA_W+15:0]   w_norm_ext;
    logic [15:0]          w_m0;
    logic [31:0]          w_sq;
    logic                 w_bit;
    logic [15:0]          w_m_next;
    logic [FRAC_BITS-1:0] w_frac_next;
    logic                 w_unused;

    // Magnitude of the operand; the most negative value wraps to 2^(DATA_W-1), which is exact as unsigned
    assign w_abs = in_x[DATA_W-1] ? (~in_x + DATA_W'(1)) : in_x;

    // Leading-one position of the captured magnitude (highest set bit wins)
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_mag[i]) begin
                w_lead = 6'(i);
            end
        end
    end

    // Left-justify the magnitude, then take the top 16 bits as the Q1.15 mantissa in [1,2)
    assign w_shift    = 6'(DATA_W - 1) - w_lead;
    assign w_norm     = r_mag << w_shift;
    assign w_norm_ext = {w_norm, 16'b0};
    assign w_m0       = w_norm_ext[DATA_W+15 -: 16];

    // Squaring step: a square >= 2 yields a 1 fraction bit and is renormalised by halving
    assign w_sq        = 32'(r_m) * 32'(r_m);
    assign w_bit       = w_sq[31];
    assign w_m_next    = w_bit ? w_sq[31:16] : w_sq[30:15];
    assign w_frac_next = {r_frac[FRAC_BITS-2:0], w_bit};

    // Truncated low product bits and zero padding below the mantissa are intentionally dropped
    assign w_unused = ^{w_sq[14:0], w_norm_ext[15:0]};

    // Conversion FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_m         <= '0;
            r_frac      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_s     <= 1'b0;
            r_out_l     <= ZERO_CODE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sign     <= in_x[DATA_W-1];
                        r_mag      <= w_abs;
                        r_in_ready <= 1'b0;
                        if (in_x == '0) begin
                            r_out_s     <= 1'b0;
                            r_out_l     <= ZERO_CODE;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    r_exp   <= w_lead;
                    r_m     <= w_m0;
                    r_frac  <= '0;
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_m    <= w_m_next;
                    r_frac <= w_frac_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(FRAC_BITS - 1)) begin
                        r_out_s     <= r_sign;
                        r_out_l     <= LOG_W'({r_exp, w_frac_next});
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_l     = r_out_l;

endmodule

// File: tb/tb_lau_lin2log.sv
// tb/tb_lau_lin2log.sv - directed self-checking bench for lau_lin2log
module tb_lau_lin2log;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic        out_s;
    logic [15:0] out_l;

    int checks = 0;
    int errors = 0;

    lau_lin2log #(
        .DATA_W    (16),
        .FRAC_BITS (10),
        .LOG_W     (16),
        .ZERO_CODE (16'hFF1C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_l     (out_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents x, waits for the result; lat counts edges inclusive of the accept edge
    task automatic convert(input logic [15:0] x, output logic s, output logic [15:0] l,
                           output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        in_x     = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x     = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = out_s;
        l = out_l;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] vx   [4] = '{16'd2, 16'd4, 16'hFFF8, 16'h8000};
    logic        vs   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] vl   [4] = '{16'h0400, 16'h0800, 16'h0C00, 16'h3C00};

    initial begin
        logic        s;
        logic [15:0] l;
        int          lat;
        logic        seen;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_x      = 16'd1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_l", out_l, 16'hFF1C);
        chk("rst_out_s", out_s, 0);
        rst_n = 1'b1;

        convert(16'd1, s, l, lat);
        chk("x1_latency", lat, 12);
        chk("x1_s", s, 0);
        chk("x1_l", l, 16'h0000);
        release_out();
        chk("x1_back_idle", in_ready, 1);
        chk("x1_valid_drop", out_valid, 0);

        for (int i = 0; i < 4; i++) begin
            convert(vx[i], s, l, lat);
            chk($sformatf("vec%0d_latency", i), lat, 12);
            chk($sformatf("vec%0d_s", i), s, vs[i]);
            chk($sformatf("vec%0d_l", i), l, vl[i]);
            release_out();
        end

        in_valid = 1'b1;
        in_x     = 16'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_s", out_s, 0);
        chk("abort_out_l", out_l, 16'hFF1C);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("abort_no_stale_valid", seen, 0);
        chk("abort_idle", in_ready, 1);
        convert(16'hFFF8, s, l, lat);
        chk("post_abort_latency", lat, 12);
        chk("post_abort_s", s, 1);
        chk("post_abort_l", l, 16'h0C00);
        release_out();

        convert(16'd0, s, l, lat);
        chk("zero_latency", lat, 1);
        chk("zero_s", s, 0);
        chk("zero_l", l, 16'hFF1C);
        release_out();

        convert(16'd3, s, l, lat);
        chk("x3_latency", lat, 12);
        chk("x3_s", s, 0);
        chk("x3_l", l, 16'h0656);
        release_out();

        convert(16'd32767, s, l, lat);
        chk("max_s", s, 0);
        chk("max_int", l[15:10], 14);
        chk("max_frac_ge_3fe", (l[9:0] >= 10'h3FE), 1);
        release_out();

        convert(16'd4, s, l, lat);
        chk("hold_first_l", l, 16'h0800);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_x     = 16'($urandom);
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", i), out_valid, 1);
            chk($sformatf("hold%0d_s", i), out_s, 0);
            chk($sformatf("hold%0d_l", i), out_l, 16'h0800);
            chk($sformatf("hold%0d_in_ready", i), in_ready, 0);
        end
        in_valid = 1'b0;
        release_out();
        chk("hold_release_idle", in_ready, 1);
        chk("hold_release_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_no_second_operand", out_valid, 0);
        chk("hold_still_idle", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
